instruction_memory: RTL and testbench

INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

---
 rtl/instruction_memory_pkg.sv | 23 ++
 rtl/instruction_memory_if.sv | 25 ++
 rtl/imem_array.sv | 35 +++
 rtl/instruction_memory.sv | 130 +++++++++++++
 tb/tb_instruction_memory.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_memory_pkg.sv
// Shared constants, types and helpers for the instruction memory slice.
package instruction_memory_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [WORD_W-1:0] FAULT_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_load_t;

  // A byte address is unusable if it is not word aligned or lies past the array.
  function automatic logic addr_fault(input logic [WORD_W-1:0] addr, input int unsigned aw);
    return (addr[1:0] != 2'b00) || ((addr >> (aw + 32'd2)) != '0);
  endfunction

endpackage

// File: rtl/instruction_memory_if.sv
// Fetch request/response and program-load bus of the instruction memory.
interface instruction_memory_if;
  import instruction_memory_pkg::*;

  logic              req_i;
  logic [WORD_W-1:0] addr_i;
  logic              flush_i;
  logic              load_en_i;
  logic [WORD_W-1:0] load_addr_i;
  logic [WORD_W-1:0] load_data_i;
  logic              ready_o;
  logic              valid_o;
  logic [WORD_W-1:0] instr_o;
  logic              fault_o;

  modport master (
    output req_i, addr_i, flush_i, load_en_i, load_addr_i, load_data_i,
    input  ready_o, valid_o, instr_o, fault_o
  );

  modport slave (
    input  req_i, addr_i, flush_i, load_en_i, load_addr_i, load_data_i,
    output ready_o, valid_o, instr_o, fault_o
  );
endinterface

// File: rtl/imem_array.sv
// Word storage with one synchronous write port and one registered read port.
module imem_array
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic              rclr,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Contents survive reset; only the load strobe changes them.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-edge write is not visible here: the read samples the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= FAULT_INSTR;
    end else if (re) begin
      rdata <= rclr ? FAULT_INSTR : mem[raddr];
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction fetch memory: latency-programmable request/response with flush and program load.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_memory_if.slave  bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic        ZERO_LAT = (LATENCY == 0);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ready_q;
  logic              valid_q;
  logic              fault_q;
  logic              fault_pend_q;
  logic              accept;
  logic              resp_fire;
  logic              req_fault;
  logic              load_ok;
  logic [AW-1:0]     req_idx;
  logic [WORD_W-1:0] rd_data;
  imem_load_t        load;

  assign req_fault = addr_fault(bus.addr_i, AW);
  assign req_idx   = bus.addr_i[AW+1:2];
  assign load      = '{addr: bus.load_addr_i, data: bus.load_data_i};
  assign load_ok   = bus.load_en_i && !addr_fault(load.addr, AW);
  assign accept    = bus.req_i && ready_q && !bus.flush_i;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (load_ok),
    .waddr (load.addr[AW+1:2]),
    .wdata (load.data),
    .re    (accept),
    .rclr  (req_fault),
    .raddr (req_idx),
    .rdata (rd_data)
  );

  // Next state; resp_fire marks the edge on which a response is launched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resp_fire = 1'b0;
    if (bus.flush_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (state_q == ST_RESP) state_d = ST_IDLE;
          if (accept) begin
            if (ZERO_LAT) begin
              state_d   = ST_RESP;
              resp_fire = 1'b1;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = CNT_W'(LATENCY);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_d   = ST_RESP;
            resp_fire = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d != ST_WAIT);
      valid_q <= (state_d == ST_RESP);
      if (accept) fault_pend_q <= req_fault;
      if (resp_fire) fault_q <= ZERO_LAT ? req_fault : fault_pend_q;
    end
  end

  // With no wait cycles the array read register is the response itself; otherwise
  // it is copied out only when the response launches so instr_o holds meanwhile.
  if (LATENCY == 0) begin : g_direct
    assign bus.instr_o = rd_data;
  end else begin : g_hold
    logic [WORD_W-1:0] instr_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        instr_q <= FAULT_INSTR;
      end else if (resp_fire) begin
        instr_q <= rd_data;
      end
    end
    assign bus.instr_o = instr_q;
  end

  assign bus.ready_o = ready_q;
  assign bus.valid_o = valid_q;
  assign bus.fault_o = fault_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized bench for instruction_memory at LATENCY=2 and LATENCY=0 against a response-schedule model.
module tb_instruction_memory;

  localparam int unsigned D2 = 64;
  localparam int unsigned D0 = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, flush, ld_en;
  logic [31:0] addr, ld_addr, ld_data;

  int total = 0;
  int bad   = 0;
  int unsigned edge_n = 0;

  // Model: memory image per DUT and at most one scheduled response per DUT.
  logic [31:0] mem_m [2][64];
  logic        pend_v [2];
  int unsigned pend_due [2];
  logic [31:0] pend_instr [2];
  logic        pend_fault [2];
  logic        exp_ready [2];
  logic        exp_valid [2];
  logic        exp_fault [2];
  logic [31:0] exp_instr [2];

  instruction_memory_if bus2();
  instruction_memory_if bus0();

  assign bus2.req_i = req;       assign bus0.req_i = req;
  assign bus2.addr_i = addr;     assign bus0.addr_i = addr;
  assign bus2.flush_i = flush;   assign bus0.flush_i = flush;
  assign bus2.load_en_i = ld_en; assign bus0.load_en_i = ld_en;
  assign bus2.load_addr_i = ld_addr; assign bus0.load_addr_i = ld_addr;
  assign bus2.load_data_i = ld_data; assign bus0.load_data_i = ld_data;

  instruction_memory #(.DEPTH(D2), .LATENCY(2)) u_l2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  instruction_memory #(.DEPTH(D0), .LATENCY(0)) u_l0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  always #5 clk = ~clk;

  function automatic int unsigned dep(input int k);
    return (k == 0) ? D2 : D0;
  endfunction

  function automatic int unsigned lat(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic bad_addr(input logic [31:0] a, input int k);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * dep(k)));
  endfunction

  function automatic logic [31:0] gen_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 255)) | 32'd1;
    if (r == 1) return 32'($urandom) & 32'hFFFF_FFFC;
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend_v[k]    = 1'b0;
      exp_ready[k] = 1'b1;
      exp_valid[k] = 1'b0;
      exp_fault[k] = 1'b0;
      exp_instr[k] = 32'h0;
    end
  endtask

  // Response appears after edge N for zero latency, otherwise after edge N+1+LATENCY.
  task automatic model_edge(input int k);
    logic acc;
    logic f;
    acc = req && exp_ready[k] && !flush;
    if (flush) pend_v[k] = 1'b0;
    if (acc) begin
      f             = bad_addr(addr, k);
      pend_v[k]     = 1'b1;
      pend_due[k]   = edge_n + ((lat(k) == 0) ? 0 : lat(k) + 1);
      pend_fault[k] = f;
      pend_instr[k] = f ? 32'h0 : mem_m[k][addr[7:2]];
    end
    exp_valid[k] = 1'b0;
    if (pend_v[k] && pend_due[k] == edge_n) begin
      exp_valid[k] = 1'b1;
      exp_instr[k] = pend_instr[k];
      exp_fault[k] = pend_fault[k];
      pend_v[k]    = 1'b0;
    end
    exp_ready[k] = !pend_v[k];
    if (ld_en && !bad_addr(ld_addr, k)) mem_m[k][ld_addr[7:2]] = ld_data;
  endtask

  task automatic compare();
    check("l2_ready", 32'(bus2.ready_o), 32'(exp_ready[0]));
    check("l2_valid", 32'(bus2.valid_o), 32'(exp_valid[0]));
    check("l2_instr", bus2.instr_o, exp_instr[0]);
    check("l2_fault", 32'(bus2.fault_o), 32'(exp_fault[0]));
    check("l0_ready", 32'(bus0.ready_o), 32'(exp_ready[1]));
    check("l0_valid", 32'(bus0.valid_o), 32'(exp_valid[1]));
    check("l0_instr", bus0.instr_o, exp_instr[1]);
    check("l0_fault", 32'(bus0.fault_o), 32'(exp_fault[1]));
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (!rst_n) model_reset();
    else begin
      model_edge(0);
      model_edge(1);
    end
    #1 compare();
  endtask

  task automatic idle();
    req = 1'b0; flush = 1'b0; ld_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    idle();
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic wait_valid2(input string tag);
    int n;
    n = 0;
    while (!bus2.valid_o && n < 12) begin
      step();
      n++;
    end
    if (!bus2.valid_o) check(tag, 32'h0, 32'h1);
  endtask

  task automatic assert_reset();
    idle();
    rst_n = 1'b0;
    #1 model_reset();
    compare();
  endtask

  initial begin
    logic [31:0] w0, w1, w2;
    rst_n = 1'b0; addr = '0; ld_addr = '0; ld_data = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 model_reset();
    compare();
    check("rst_ready", 32'(bus2.ready_o), 32'h1);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 64; i++) load(32'(i * 4), $urandom);

    // Load then fetch with two wait cycles: response only after the third edge.
    load(32'h8, 32'hE3A0_0001);
    req = 1'b1; addr = 32'h8; step(); req = 1'b0;
    step(); check("lat_n1_valid", 32'(bus2.valid_o), 32'h0);
    step(); check("lat_n2_valid", 32'(bus2.valid_o), 32'h0);
    step(); check("lat_n3_valid", 32'(bus2.valid_o), 32'h1);
    check("lat_n3_instr", bus2.instr_o, 32'hE3A0_0001);
    check("lat_n3_fault", 32'(bus2.fault_o), 32'h0);
    step(); check("lat_n4_valid", 32'(bus2.valid_o), 32'h0);
    check("lat_hold_instr", bus2.instr_o, 32'hE3A0_0001);

    // Misaligned and out-of-range fetches fault with a zero instruction.
    req = 1'b1; addr = 32'h6; step(); idle();
    wait_valid2("mis_timeout");
    check("mis_fault", 32'(bus2.fault_o), 32'h1);
    check("mis_instr", bus2.instr_o, 32'h0);
    step();
    req = 1'b1; addr = 32'(4 * D2); step(); idle();
    wait_valid2("oor_timeout");
    check("oor_fault", 32'(bus2.fault_o), 32'h1);
    repeat (2) step();

    // Flush in the first wait cycle cancels the response.
    req = 1'b1; addr = 32'h0; step();
    req = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    check("flush_ready", 32'(bus2.ready_o), 32'h1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("flush_no_valid", 32'(bus2.valid_o), 32'h0);
    end

    // Back-to-back zero-latency fetches.
    w0 = mem_m[1][0]; w1 = mem_m[1][1]; w2 = mem_m[1][2];
    req = 1'b1; addr = 32'h0; step();
    check("b2b0_valid", 32'(bus0.valid_o), 32'h1); check("b2b0_instr", bus0.instr_o, w0);
    addr = 32'h4; step();
    check("b2b1_valid", 32'(bus0.valid_o), 32'h1); check("b2b1_instr", bus0.instr_o, w1);
    addr = 32'h8; step();
    check("b2b2_valid", 32'(bus0.valid_o), 32'h1); check("b2b2_instr", bus0.instr_o, w2);
    idle(); step();
    check("b2b_end_valid", 32'(bus0.valid_o), 32'h0);
    repeat (4) step();

    // Load and fetch of the same word on one edge return the old word.
    load(32'h10, 32'h0);
    req = 1'b1; addr = 32'h10; ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'hDEAD_BEEF;
    step(); idle();
    wait_valid2("rw_timeout");
    check("rw_old", bus2.instr_o, 32'h0);
    req = 1'b1; addr = 32'h10; step(); idle();
    wait_valid2("rw2_timeout");
    check("rw_new", bus2.instr_o, 32'hDEAD_BEEF);
    repeat (2) step();

    // Reset in the middle of a wait discards the request.
    req = 1'b1; addr = 32'h0; step(); idle(); step();
    assert_reset();
    check("mrst_ready", 32'(bus2.ready_o), 32'h1);
    check("mrst_valid", 32'(bus2.valid_o), 32'h0);
    check("mrst_instr", bus2.instr_o, 32'h0);
    check("mrst_fault", 32'(bus2.fault_o), 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("mrst_no_valid", 32'(bus2.valid_o), 32'h0);
    end

    // Random traffic with flushes, loads and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        assert_reset();
        step();
        rst_n = 1'b1;
        continue;
      end
      req     = ($urandom_range(0, 9) < 6);
      flush   = ($urandom_range(0, 9) == 0);
      addr    = gen_addr();
      ld_en   = ($urandom_range(0, 3) == 0);
      ld_addr = gen_addr();
      ld_data = $urandom;
      step();
    end
    idle();
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

endmodule
